hwt_event_trigger: RTL and testbench
====================================

// Module: hwt_event_trigger
// PURPOSE
//   Sequential trigger stage downstream of the combinational HWT detect node.
//   - Consumes the node's 1-bit output y_in and counts its rising edges while armed.
//   - After THRESH edges, asserts trig (payload enable) for PULSE_LEN cycles.
//   - Converts a stateless "non-active" detect into a time-bomb-style active trigger.
// PARAMETERS
//   CNT_W      8   width of edge counter and count port
//   THRESH     4   rising edges required to fire; legal range 1..2**CNT_W-1
//   PULSE_LEN  2   cycles trig stays high per firing; >=1
//   WINDOW     16  max cycles between edges (used only with HWT_WINDOW_EN); >=2
// PORTS
//   clk    in   1      single clock, all flops rising-edge
//   rst_n  in   1      asynchronous, active-low reset
//   y_in   in   1      detect node output, synchronous to clk
//   arm    in   1      level enable; 0 forces IDLE
//   clr    in   1      synchronous clear; highest priority after reset
//   trig   out  1      registered payload enable
//   count  out  CNT_W  registered edges counted in current attempt
//   busy   out  1      registered, 1 when state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, count=0, trig=0, busy=0, y_q=0.
//   Edge detect: y_q <= y_in every cycle; rise = y_in & ~y_q (comb).
//     A rise sampled at edge k updates count at edge k (0-cycle latency).
//   States: IDLE, COUNT, FIRE. Priority per cycle: clr > arm=0 > rise.
//   IDLE:  count=0, trig=0. arm=1 & clr=0 -> COUNT next cycle; rise in this cycle ignored.
//   COUNT:
//     - rise & count<THRESH-1 -> count+1.
//     - rise & count==THRESH-1 -> count=THRESH, go FIRE, trig=1 at same edge.
//     - arm=0 -> IDLE, count=0; a simultaneous rise is dropped.
//   FIRE:
//     - trig=1 for exactly PULSE_LEN cycles; rises ignored; count holds THRESH.
//     - At pulse end: trig=0, count=0; arm=1 -> COUNT, arm=0 -> IDLE.
//     - arm=0 mid-pulse -> IDLE immediately, trig=0 (pulse truncated).
//   clr=1 in any state -> IDLE, count=0, trig=0 at next edge.
//   count never wraps; it saturates at THRESH. Pulse timer width = $clog2(PULSE_LEN+1).
//   busy = (state!=IDLE), registered with state.
// CONFIGURATION
//   HWT_WINDOW_EN defined:
//     - Gap counter is cleared on every rise in COUNT and increments otherwise.
//     - If gap reaches WINDOW while in COUNT with count>0: count=0, state stays COUNT.
//     - A rise in the same cycle the gap reaches WINDOW counts as a new first edge (count=1).
//   HWT_WINDOW_EN undefined: no gap counter; edges may be arbitrarily far apart.
// STRUCTURE
//   hwt_pkg:
//     - typedef enum logic [1:0] {IDLE=2'd0, COUNT=2'd1, FIRE=2'd2} hwt_state_t
//     - localparam defaults for CNT_W, THRESH, PULSE_LEN, WINDOW.
//   Sub-module hwt_edge_det (clk, rst_n, d, rise): the y_q flop plus rise logic;
//     reused by other trigger stages.
//   Top holds the FSM, edge counter, pulse timer, and optional gap counter.
// TESTING
//   T1 reset: assert rst_n=0 mid-FIRE -> trig, count, busy drop to 0 asynchronously.
//   T2 arm=1, 4 y_in pulses spaced 3 cycles -> count 1,2,3,4; trig=1 for exactly
//      2 cycles; then count=0, state COUNT.
//   T3 arm=1, 3 rises, then arm=0 on the cycle of the 4th rise -> no trig, count=0,
//      busy=0.
//   T4 y_in held high 20 cycles -> exactly one rise counted (count=1).
//   T5 clr=1 coincident with the 4th rise -> no trig, IDLE, count=0.
//   T6 HWT_WINDOW_EN, WINDOW=16:
//      - rises 20 cycles apart -> count never exceeds 1, no trig.
//      - rises 10 cycles apart -> trig after the 4th rise.

Source files
------------

// File: rtl/hwt_pkg.sv
// Shared types and default parameters for the HWT trigger stages.
package hwt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } hwt_state_t;

  localparam int CNT_W_DEF     = 8;
  localparam int THRESH_DEF    = 4;
  localparam int PULSE_LEN_DEF = 2;
  localparam int WINDOW_DEF    = 16;

endpackage

// File: rtl/hwt_edge_det.sv
// Rising-edge detector: one history flop plus a combinational rise strobe.
module hwt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= 1'b0;
    else        y_q <= d;
  end

  assign rise = d & ~y_q;

endmodule

// File: rtl/hwt_event_trigger.sv
// Counts detect-node rising edges while armed and fires a PULSE_LEN-cycle trig.
// Optional inter-edge timeout is enabled by defining HWT_WINDOW_EN.
module hwt_event_trigger
  import hwt_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int THRESH    = THRESH_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int WINDOW    = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             arm,
  input  logic             clr,
  output logic             trig,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  localparam int TMR_W = $clog2(PULSE_LEN + 1);

  hwt_state_t       state, state_d;
  logic [CNT_W-1:0] count_d, cnt_base;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic             trig_d;
  logic             rise;

  hwt_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (y_in),
    .rise (rise)
  );

`ifdef HWT_WINDOW_EN
  localparam int GAP_W = $clog2(WINDOW + 1);
  logic [GAP_W-1:0] gap, gap_d;
  logic             timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap <= '0;
    else        gap <= gap_d;
  end
`endif

  always_comb begin
    state_d  = state;
    count_d  = count;
    trig_d   = trig;
    tmr_d    = tmr;
    cnt_base = count;
`ifdef HWT_WINDOW_EN
    gap_d    = '0;
    timeout  = 1'b0;
`endif
    if (clr || !arm) begin
      state_d = IDLE;
      count_d = '0;
      trig_d  = 1'b0;
      tmr_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = COUNT;
          count_d = '0;
          trig_d  = 1'b0;
        end
        COUNT: begin
`ifdef HWT_WINDOW_EN
          // A stale partial count restarts; a coincident rise becomes the new first edge.
          timeout = (count != '0) && (gap == GAP_W'(WINDOW - 1));
          if (timeout) cnt_base = '0;
          if (rise || timeout)              gap_d = '0;
          else if (gap == GAP_W'(WINDOW - 1)) gap_d = gap;
          else                              gap_d = gap + 1'b1;
`endif
          count_d = cnt_base;
          if (rise) begin
            if (cnt_base < CNT_W'(THRESH - 1)) begin
              count_d = cnt_base + 1'b1;
            end else begin
              count_d = CNT_W'(THRESH);
              state_d = FIRE;
              trig_d  = 1'b1;
              tmr_d   = TMR_W'(PULSE_LEN - 1);
            end
          end
        end
        FIRE: begin
          // tmr holds the remaining high cycles after the current one.
          if (tmr == '0) begin
            state_d = COUNT;
            count_d = '0;
            trig_d  = 1'b0;
          end else begin
            tmr_d = tmr - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          trig_d  = 1'b0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      trig  <= 1'b0;
      tmr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      trig  <= trig_d;
      tmr   <= tmr_d;
      busy  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_hwt_event_trigger.sv
// Directed self-checking bench for hwt_event_trigger (THRESH=4, PULSE_LEN=2, WINDOW=16).
module tb_hwt_event_trigger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       y_in = 1'b0;
  logic       arm = 1'b0;
  logic       clr = 1'b0;
  logic       trig;
  logic [7:0] count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  hwt_event_trigger #(
    .CNT_W    (8),
    .THRESH   (4),
    .PULSE_LEN(2),
    .WINDOW   (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .y_in (y_in),
    .arm  (arm),
    .clr  (clr),
    .trig (trig),
    .count(count),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    y_in  = 1'b0;
    arm   = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // One-cycle y_in pulse followed by (spacing-1) low cycles.
  task automatic pulse(input int spacing);
    y_in = 1'b1;
    cyc(1);
    y_in = 1'b0;
    cyc(spacing - 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({trig, busy, count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state trig=%0b busy=%0b count=%0d expected all 0", trig, busy, count);
    end
  endtask

  task automatic test_count_fire();
    do_reset();
    arm = 1'b1;
    cyc(1);
    checks++;
    if (busy !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL arm_to_count busy=%0b count=%0d expected busy=1 count=0", busy, count);
    end
    for (int i = 0; i < 4; i++) begin
      y_in = 1'b1;
      cyc(1);
      checks++;
      if (count !== 8'(i + 1) || trig !== (i == 3)) begin
        errors++;
        $display("FAIL edge_count[%0d] count=%0d trig=%0b expected count=%0d trig=%0b",
                 i, count, trig, i + 1, (i == 3));
      end
      y_in = 1'b0;
      if (i < 3) cyc(2);
    end
    cyc(1);
    checks++;
    if (trig !== 1'b1 || count !== 8'd4) begin
      errors++;
      $display("FAIL pulse_second_cycle trig=%0b count=%0d expected trig=1 count=4", trig, count);
    end
    cyc(1);
    checks++;
    if (trig !== 1'b0 || count !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pulse_end trig=%0b count=%0d busy=%0b expected 0/0/1", trig, count, busy);
    end
    pulse(3);
    checks++;
    if (count !== 8'd1 || trig !== 1'b0) begin
      errors++;
      $display("FAIL recount_after_fire count=%0d trig=%0b expected count=1 trig=0", count, trig);
    end
  endtask

  task automatic test_async_reset_fire();
    do_reset();
    arm = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse(3);
    y_in = 1'b1;
    cyc(1);
    checks++;
    if (trig !== 1'b1) begin
      errors++;
      $display("FAIL fire_before_reset trig=%0b expected 1", trig);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({trig, busy, count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset trig=%0b busy=%0b count=%0d expected all 0", trig, busy, count);
    end
    y_in = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_disarm();
    do_reset();
    arm = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse(3);
    checks++;
    if (count !== 8'd3) begin
      errors++;
      $display("FAIL disarm_precount count=%0d expected 3", count);
    end
    y_in = 1'b1;
    arm  = 1'b0;
    cyc(1);
    checks++;
    if (trig !== 1'b0 || count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL disarm_on_4th trig=%0b count=%0d busy=%0b expected 0/0/0", trig, count, busy);
    end
    y_in = 1'b0;
    cyc(1);
  endtask

  task automatic test_truncate();
    do_reset();
    arm = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse(3);
    y_in = 1'b1;
    cyc(1);
    y_in = 1'b0;
    arm  = 1'b0;
    cyc(1);
    checks++;
    if (trig !== 1'b0 || count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL truncate trig=%0b count=%0d busy=%0b expected 0/0/0", trig, count, busy);
    end
  endtask

  task automatic test_held_high();
    do_reset();
    arm = 1'b1;
    cyc(1);
    y_in = 1'b1;
    cyc(1);
    checks++;
    if (count !== 8'd1) begin
      errors++;
      $display("FAIL held_first count=%0d expected 1", count);
    end
    cyc(19);
    checks++;
    if (count !== 8'd1 || trig !== 1'b0) begin
      errors++;
      $display("FAIL held_high count=%0d trig=%0b expected count=1 trig=0", count, trig);
    end
    y_in = 1'b0;
    cyc(1);
  endtask

  task automatic test_clr();
    do_reset();
    arm = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse(3);
    y_in = 1'b1;
    clr  = 1'b1;
    cyc(1);
    checks++;
    if (trig !== 1'b0 || count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_on_4th trig=%0b count=%0d busy=%0b expected 0/0/0", trig, count, busy);
    end
    y_in = 1'b0;
    clr  = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL rearm_after_clr busy=%0b count=%0d expected busy=1 count=0", busy, count);
    end
  endtask

`ifdef HWT_WINDOW_EN
  task automatic test_window();
    int max_cnt;
    do_reset();
    arm = 1'b1;
    cyc(1);
    max_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      y_in = 1'b1;
      cyc(1);
      y_in = 1'b0;
      for (int c = 0; c < 19; c++) begin
        if (int'(count) > max_cnt) max_cnt = int'(count);
        checks++;
        if (trig !== 1'b0) begin
          errors++;
          $display("FAIL window_slow_trig trig=%0b expected 0", trig);
        end
        cyc(1);
      end
    end
    checks++;
    if (max_cnt != 1) begin
      errors++;
      $display("FAIL window_slow_max count=%0d expected 1", max_cnt);
    end
    do_reset();
    arm = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse(10);
    y_in = 1'b1;
    cyc(1);
    checks++;
    if (trig !== 1'b1 || count !== 8'd4) begin
      errors++;
      $display("FAIL window_fast trig=%0b count=%0d expected trig=1 count=4", trig, count);
    end
    y_in = 1'b0;
    cyc(3);
  endtask
`endif

  initial begin
    test_reset();
    test_count_fire();
    test_async_reset_fire();
    test_disarm();
    test_truncate();
    test_held_high();
    test_clr();
`ifdef HWT_WINDOW_EN
    test_window();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
